// File: rtl/turn_signal_conditioner.sv
// Turn-switch conditioner: sync, debounce, step tick, tick-aligned requests.
// Feeds clean left/right/hazard requests to the tail-light sequencer.
module turn_signal_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic left_sw,
  input  logic right_sw,
  output logic tick,
  output logic left,
  output logic right,
  output logic hazard,
  output logic req_chg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

  logic [SYNC_STAGES-1:0] sync_l;
  logic [SYNC_STAGES-1:0] sync_r;
  logic           s_l;
  logic           s_r;
  logic           d_l;
  logic           d_r;
  logic [CW-1:0]  c_l;
  logic [CW-1:0]  c_r;
  logic           d_l_nxt;
  logic           d_r_nxt;
  logic [CW-1:0]  c_l_nxt;
  logic [CW-1:0]  c_r_nxt;
  logic [TW-1:0]  t;

  assign s_l = sync_l[SYNC_STAGES-1];
  assign s_r = sync_r[SYNC_STAGES-1];

  function automatic logic [CW:0] deb_next(
    input logic          s,
    input logic          d,
    input logic [CW-1:0] c
  );
    logic [CW:0] r;
    r = {d, {CW{1'b0}}};
    if (s != d) begin
      if (c == CMAX) r = {s, {CW{1'b0}}};
      else           r = {d, c + CW'(1)};
    end
    return r;
  endfunction

  // Shift raw switches through the synchronizer chains
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_l <= '0;
      sync_r <= '0;
    end else begin
      sync_l <= {sync_l[SYNC_STAGES-2:0], left_sw};
      sync_r <= {sync_r[SYNC_STAGES-2:0], right_sw};
    end
  end

  // Next debounce state for both channels
  always_comb begin
    {d_l_nxt, c_l_nxt} = deb_next(s_l, d_l, c_l);
    {d_r_nxt, c_r_nxt} = deb_next(s_r, d_r, c_r);
  end

  // Debounce counters and debounced values
  always_ff @(posedge clk) begin
    if (reset) begin
      d_l <= 1'b0;
      d_r <= 1'b0;
      c_l <= '0;
      c_r <= '0;
    end else begin
      d_l <= d_l_nxt;
      d_r <= d_r_nxt;
      c_l <= c_l_nxt;
      c_r <= c_r_nxt;
    end
  end

  // Step tick: one cycle high every TICK_DIV cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      t    <= '0;
      tick <= 1'b0;
    end else if (t == TMAX) begin
      t    <= '0;
      tick <= 1'b1;
    end else begin
      t    <= t + TW'(1);
      tick <= 1'b0;
    end
  end

  // Requests only move on tick edges, using pre-edge debounced values
  always_ff @(posedge clk) begin
    if (reset) begin
      left    <= 1'b0;
      right   <= 1'b0;
      hazard  <= 1'b0;
      req_chg <= 1'b0;
    end else if (tick) begin
      left    <= d_l;
      right   <= d_r;
      hazard  <= d_l & d_r;
      req_chg <= ({d_l, d_r} != {left, right});
    end else begin
      req_chg <= 1'b0;
    end
  end

endmodule
